// File: rtl/multi_ch_data_sync.sv
// Multi-channel clock-domain data synchroniser.
// Each channel's asynchronous enable passes through a flop chain and an edge
// detector. A detected event captures that channel's data word into a holding
// slot. A round-robin arbiter then moves held words, one at a time, into a
// single valid/ready output register.
module multi_ch_data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int EDGE_MODE  = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic                        sync_ready,
  input  logic                        ovf_clr,
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        sync_valid,
  output logic                        enable_pulse,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           overflow
);

  // Synchroniser and edge-detect state
  logic [NUM_CH-1:0]     sync_q [NUM_STAGES];
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_STAGES:0]   prime_q;
  logic [NUM_CH-1:0]     sync_w;
  logic [NUM_CH-1:0]     edge_w;
  logic [NUM_CH-1:0]     event_w;

  // Holding slots
  logic [BUS_WIDTH-1:0]  hold_q [NUM_CH];
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0]     overflow_q, overflow_d;
  logic [NUM_CH-1:0]     slot_free;

  // Arbiter and output stage
  logic [CH_W-1:0]       rr_q;
  logic [CH_W-1:0]       cand;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_vld;
  logic [NUM_CH-1:0]     grant_vec;
  logic [BUS_WIDTH-1:0]  sync_bus_q;
  logic [CH_W-1:0]       sync_ch_q;
  logic                  sync_valid_q;
  logic                  enable_pulse_q;
  logic [NUM_CH-1:0]     ack_toggle_q;

  // Enable synchroniser chain, edge-detect history and a fill marker that
  // becomes all-ones once prev_q holds a real post-reset sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < NUM_STAGES; s++) sync_q[s] <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      // NOTE: state updates use <= so every flop samples pre-edge values,
      // which keeps the chain a true shift register regardless of order.
      sync_q[0] <= bus_enable;
      for (int s = 1; s < NUM_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q  <= sync_q[NUM_STAGES-1];
      prime_q <= {prime_q[NUM_STAGES-1:0], 1'b1};
    end
  end

  // Events are suppressed until the chain is filled, so an enable that was
  // already high at reset release is not mistaken for a fresh edge.
  assign sync_w  = sync_q[NUM_STAGES-1];
  assign edge_w  = (EDGE_MODE == 0) ? (sync_w & ~prev_q) : (sync_w ^ prev_q);
  assign event_w = prime_q[NUM_STAGES] ? edge_w : '0;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    cand      = '0;
    if (!sync_valid_q || sync_ready) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        cand = CH_W'((int'(rr_q) + off) % NUM_CH);
        if (!grant_vld && pending_q[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) grant_vec[grant_idx] = 1'b1;
  end

  // A slot accepts new data when empty or when it is emptied at this edge.
  assign slot_free  = ~pending_q | grant_vec;
  assign pending_d  = (pending_q & ~grant_vec) | (event_w & slot_free);
  assign overflow_d = (event_w & ~slot_free) | (overflow_q & ~{NUM_CH{ovf_clr}});

  // Per-channel holding registers, pending bits and sticky overflow flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the holding array is cleared on reset so no stale word can
      // ever be presented after a mid-operation reset.
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (event_w[k] && slot_free[k]) begin
          hold_q[k] <= Unsync_bus[k*BUS_WIDTH +: BUS_WIDTH];
        end
      end
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Output register: load on grant, drop valid once accepted with nothing new.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_bus_q     <= '0;
      sync_ch_q      <= '0;
      sync_valid_q   <= 1'b0;
      enable_pulse_q <= 1'b0;
      ack_toggle_q   <= '0;
      rr_q           <= CH_W'(NUM_CH - 1);
    end else begin
      enable_pulse_q <= grant_vld;
      ack_toggle_q   <= ack_toggle_q ^ grant_vec;
      if (grant_vld) begin
        sync_bus_q   <= hold_q[grant_idx];
        sync_ch_q    <= grant_idx;
        sync_valid_q <= 1'b1;
        rr_q         <= grant_idx;
      end else if (sync_ready) begin
        sync_valid_q <= 1'b0;
      end
    end
  end

  assign sync_bus     = sync_bus_q;
  assign sync_ch      = sync_ch_q;
  assign sync_valid   = sync_valid_q;
  assign enable_pulse = enable_pulse_q;
  assign ack_toggle   = ack_toggle_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_multi_ch_data_sync.sv
// Scoreboard bench for multi_ch_data_sync: one rising-edge instance and one
// toggle-mode instance share data, ready and clear inputs.
module tb_multi_ch_data_sync;

  localparam int NS       = 2;
  localparam int BW       = 8;
  localparam int NCH      = 4;
  localparam int CHW      = 2;
  localparam int HIST_MAX = 8192;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [CHW-1:0] ch;
  } exp_t;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [NCH*BW-1:0]   data = '0;
  logic [1:0][NCH-1:0] en = '0;
  logic                ready = 1'b1;
  logic                clr = 1'b0;

  logic [1:0][BW-1:0]  s_bus;
  logic [1:0][CHW-1:0] s_ch;
  logic [1:0]          s_valid;
  logic [1:0]          s_pulse;
  logic [1:0][NCH-1:0] s_ack;
  logic [1:0][NCH-1:0] s_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  multi_ch_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .EDGE_MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .Unsync_bus(data), .bus_enable(en[0]),
    .sync_ready(ready), .ovf_clr(clr),
    .sync_bus(s_bus[0]), .sync_ch(s_ch[0]), .sync_valid(s_valid[0]),
    .enable_pulse(s_pulse[0]), .ack_toggle(s_ack[0]), .overflow(s_ovf[0]));

  multi_ch_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH), .EDGE_MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .Unsync_bus(data), .bus_enable(en[1]),
    .sync_ready(ready), .ovf_clr(clr),
    .sync_bus(s_bus[1]), .sync_ch(s_ch[1]), .sync_valid(s_valid[1]),
    .enable_pulse(s_pulse[1]), .ack_toggle(s_ack[1]), .overflow(s_ovf[1]));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: enable samples indexed by edge number since reset, a
  // set of holding slots, and a round-robin delivery order.
  logic [NCH-1:0]      m_hist [2][HIST_MAX];
  logic [BW-1:0]       m_hold [2][NCH];
  logic [1:0][NCH-1:0] m_pend, m_ovf, m_ack;
  logic [1:0]          m_valid, m_pulse;
  int                  m_rr [2];
  int                  m_t  [2];
  exp_t                exp0 [$];
  exp_t                exp1 [$];

  logic [1:0][BW-1:0]  last_bus;
  logic [1:0][CHW-1:0] last_ch;
  int                  delivered [2];
  int                  log_ch [$];
  int                  log_cyc [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i]  = 0;
      m_rr[i] = NCH - 1;
      for (int k = 0; k < NCH; k++) m_hold[i][k] = '0;
    end
    m_pend = '0; m_ovf = '0; m_ack = '0; m_valid = '0; m_pulse = '0;
    last_bus = '0; last_ch = '0;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic model_step(input int i, input int mode);
    logic [NCH-1:0] ev, s, p;
    logic [BW-1:0]  gdata;
    exp_t           e;
    int             g;
    m_t[i]++;
    ev = '0;
    if (m_t[i] < HIST_MAX) begin
      m_hist[i][m_t[i]] = en[i];
      // An edge is seen when both compared samples were taken after reset.
      if (m_t[i] >= NS + 2) begin
        s  = m_hist[i][m_t[i] - NS];
        p  = m_hist[i][m_t[i] - NS - 1];
        ev = (mode == 0) ? (s & ~p) : (s ^ p);
      end
    end
    g = -1;
    if (!m_valid[i] || ready) begin
      for (int off = 1; off <= NCH; off++) begin
        int c;
        c = (m_rr[i] + off) % NCH;
        if (g < 0 && m_pend[i][c]) g = c;
      end
    end
    gdata = (g >= 0) ? m_hold[i][g] : '0;
    for (int k = 0; k < NCH; k++) begin
      if (ev[k] && m_pend[i][k] && k != g) begin
        m_ovf[i][k] = 1'b1;
      end else begin
        if (clr) m_ovf[i][k] = 1'b0;
        if (ev[k]) begin
          m_hold[i][k] = data[k*BW +: BW];
          m_pend[i][k] = 1'b1;
        end else if (k == g) begin
          m_pend[i][k] = 1'b0;
        end
      end
    end
    if (g >= 0) begin
      e.data = gdata;
      e.ch   = g[CHW-1:0];
      if (i == 0) exp0.push_back(e); else exp1.push_back(e);
      m_valid[i]   = 1'b1;
      m_pulse[i]   = 1'b1;
      m_rr[i]      = g;
      m_ack[i][g]  = ~m_ack[i][g];
    end else begin
      m_pulse[i] = 1'b0;
      if (ready) m_valid[i] = 1'b0;
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      model_reset();
    end else begin
      model_step(0, 0);
      model_step(1, 1);
    end
  end

  always @(posedge CLK) cyc++;

  // Monitor: compare flags every cycle, pop the scoreboard on every load.
  task automatic monitor_inst(input int i);
    exp_t e;
    bit   empty;
    check($sformatf("valid%0d", i), 32'(s_valid[i]), 32'(m_valid[i]));
    check($sformatf("pulse%0d", i), 32'(s_pulse[i]), 32'(m_pulse[i]));
    check($sformatf("ack%0d", i), 32'(s_ack[i]), 32'(m_ack[i]));
    check($sformatf("overflow%0d", i), 32'(s_ovf[i]), 32'(m_ovf[i]));
    if (s_pulse[i]) begin
      empty = (i == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
      if (empty) begin
        n_checks++;
        n_errors++;
        $display("FAIL word%0d: unexpected word 0x%0h ch %0d, expected none (cycle %0d)",
                 i, s_bus[i], s_ch[i], cyc);
      end else begin
        if (i == 0) e = exp0.pop_front(); else e = exp1.pop_front();
        check($sformatf("word%0d_data", i), 32'(s_bus[i]), 32'(e.data));
        check($sformatf("word%0d_ch", i), 32'(s_ch[i]), 32'(e.ch));
      end
      last_bus[i] = s_bus[i];
      last_ch[i]  = s_ch[i];
      delivered[i]++;
      if (i == 0) begin
        log_ch.push_back(int'(s_ch[0]));
        log_cyc.push_back(cyc);
      end
    end else if (s_valid[i]) begin
      check($sformatf("hold%0d_data", i), 32'(s_bus[i]), 32'(last_bus[i]));
      check($sformatf("hold%0d_ch", i), 32'(s_ch[i]), 32'(last_ch[i]));
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) monitor_inst(i);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    idle(10);
  endtask

  task automatic fire(input int i, input int k, input logic [BW-1:0] d);
    data[k*BW +: BW] = d;
    en[i][k] = 1'b1;
    idle(4);
    en[i][k] = 1'b0;
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, mark;
    model_reset();
    delivered[0] = 0;
    delivered[1] = 0;
    do_reset();

    // Single event on ch2 with exact latency.
    data[2*BW +: BW] = 8'hA5;
    en[0][2] = 1'b1;
    repeat (3) @(negedge CLK);
    check("lat_valid_early", 32'(s_valid[0]), 32'd0);
    @(negedge CLK);
    check("lat_valid", 32'(s_valid[0]), 32'd1);
    check("lat_pulse", 32'(s_pulse[0]), 32'd1);
    check("lat_data", 32'(s_bus[0]), 32'hA5);
    check("lat_ch", 32'(s_ch[0]), 32'd2);
    check("lat_ack", 32'(s_ack[0][2]), 32'd1);
    #1;
    en[0] = '0;
    idle(6);

    // All four channels at once from a fresh pointer.
    do_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    mark = log_ch.size();
    en[0] = '1;
    idle(12);
    check("rr_count", 32'(log_ch.size() - mark), 32'd4);
    if (log_ch.size() - mark == 4) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("rr_order%0d", j), 32'(log_ch[mark+j]), 32'(j));
        check($sformatf("rr_gap%0d", j), 32'(log_cyc[mark+j] - log_cyc[mark]), 32'(j));
      end
    end
    en[0] = '0;
    idle(6);

    // Backpressure and overflow on ch1.
    ready = 1'b0;
    base = delivered[0];
    fire(0, 1, 8'h11);
    fire(0, 1, 8'h22);
    fire(0, 1, 8'h33);
    idle(4);
    check("ovf_set", 32'(s_ovf[0][1]), 32'd1);
    check("ovf_held_valid", 32'(s_valid[0]), 32'd1);
    check("ovf_held_data", 32'(s_bus[0]), 32'h11);
    ready = 1'b1;
    idle(6);
    check("ovf_delivered", 32'(delivered[0] - base), 32'd2);
    check("ovf_last", 32'(last_bus[0]), 32'h22);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("ovf_cleared", 32'(s_ovf[0]), 32'd0);

    // Toggle mode: both edges of ch0 carry a word.
    base = delivered[1];
    data[0 +: BW] = 8'h3C;
    en[1][0] = 1'b1;
    idle(6);
    data[0 +: BW] = 8'hC3;
    en[1][0] = 1'b0;
    idle(8);
    check("tog_count", 32'(delivered[1] - base), 32'd2);
    check("tog_last", 32'(last_bus[1]), 32'hC3);
    check("tog_ack", 32'(s_ack[1][0]), 32'd0);

    // Randomised traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NCH; k++) begin
          if ($urandom_range(7) == 0) begin
            en[i][k] = ~en[i][k];
            data[k*BW +: BW] = BW'($urandom);
          end
        end
      end
      ready = ($urandom_range(9) < 7);
      clr   = ($urandom_range(19) == 0);
      idle(1);
    end
    ready = 1'b1;
    clr   = 1'b0;
    idle(40);
    check("drain0", 32'(exp0.size()), 32'd0);
    check("drain1", 32'(exp1.size()), 32'd0);

    // Reset while a word is pending; enable stays high across release.
    en = '0;
    idle(8);
    base = delivered[0];
    data[2*BW +: BW] = 8'h5A;
    en[0][2] = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_bus%0d", i), 32'(s_bus[i]), 32'd0);
      check($sformatf("rst_ch%0d", i), 32'(s_ch[i]), 32'd0);
      check($sformatf("rst_valid%0d", i), 32'(s_valid[i]), 32'd0);
      check($sformatf("rst_pulse%0d", i), 32'(s_pulse[i]), 32'd0);
      check($sformatf("rst_ack%0d", i), 32'(s_ack[i]), 32'd0);
      check($sformatf("rst_ovf%0d", i), 32'(s_ovf[i]), 32'd0);
    end
    idle(2);
    RST = 1'b0;
    idle(20);
    check("rst_no_word", 32'(delivered[0] - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
